// File: rtl/dht_read_scheduler.sv
// Read scheduler for a DHT-style sensor engine: issues periodic or forced
// requests, validates frames by checksum, and retries failed attempts.
module dht_read_scheduler #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int PERIOD_MS  = 2000,
  parameter int TIMEOUT_MS = 50,
  parameter int RETRY_MS   = 1100,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        force_read,
  output logic        req,
  input  logic        done,
  input  logic [39:0] raw_data,
  output logic [31:0] information,
  output logic        data_valid,
  output logic        new_data,
  output logic        err,
  output logic [1:0]  retry_cnt
);

  localparam int DIV    = CLK_FREQ / 1000;
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MAX_AB = (PERIOD_MS > TIMEOUT_MS) ? PERIOD_MS : TIMEOUT_MS;
  localparam int MAX_MS = (MAX_AB > RETRY_MS) ? MAX_AB : RETRY_MS;
  localparam int CNT_W  = $clog2(MAX_MS + 1);

  typedef enum logic [2:0] {
    S_IDLE_WAIT,
    S_REQ,
    S_WAIT_DONE,
    S_CHECK,
    S_RETRY_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   ms_q, ms_d;
  logic [39:0]        raw_q, raw_d;
  logic [31:0]        info_q, info_d;
  logic               valid_q, valid_d;
  logic               new_data_q, new_data_d;
  logic               err_q, err_d;
  logic [1:0]         retry_q, retry_d;
  logic               tick;
  logic               fail;
  logic [7:0]         sum;

  // Free-running 1 ms tick; only reset realigns its phase.
  assign tick  = (div_q == DIV_W'(DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  // 8-bit destination makes the byte sum wrap modulo 256.
  assign sum = raw_q[39:32] + raw_q[31:24] + raw_q[23:16] + raw_q[15:8];

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ms_d       = ms_q;
    raw_d      = raw_q;
    info_d     = info_q;
    valid_d    = valid_q;
    new_data_d = 1'b0;
    err_d      = err_q;
    retry_d    = retry_q;
    fail       = 1'b0;

    case (state_q)
      S_IDLE_WAIT: begin
        if (force_read || (tick && ms_q == CNT_W'(PERIOD_MS - 1))) begin
          state_d = S_REQ;
          ms_d    = '0;
        end else if (tick) begin
          ms_d = ms_q + 1'b1;
        end
      end
      S_REQ: begin
        ms_d    = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // done takes priority over a coincident timeout expiry
        if (done) begin
          raw_d   = raw_data;
          ms_d    = '0;
          state_d = S_CHECK;
        end else if (tick && ms_q == CNT_W'(TIMEOUT_MS - 1)) begin
          fail = 1'b1;
        end else if (tick) begin
          ms_d = ms_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (sum == raw_q[7:0]) begin
          info_d     = raw_q[39:8];
          valid_d    = 1'b1;
          new_data_d = 1'b1;
          err_d      = 1'b0;
          retry_d    = 2'd0;
          state_d    = S_IDLE_WAIT;
        end else begin
          fail = 1'b1;
        end
      end
      S_RETRY_GAP: begin
        if (tick && ms_q == CNT_W'(RETRY_MS - 1)) begin
          state_d = S_REQ;
          ms_d    = '0;
        end else if (tick) begin
          ms_d = ms_q + 1'b1;
        end
      end
      default: state_d = S_IDLE_WAIT;
    endcase

    if (fail) begin
      ms_d = '0;
      if (retry_q == 2'(MAX_RETRY)) begin
        err_d   = 1'b1;
        retry_d = 2'd0;
        state_d = S_IDLE_WAIT;
      end else begin
        retry_d = retry_q + 2'd1;
        state_d = S_RETRY_GAP;
      end
    end
  end

  // NOTE: non-blocking assignments so every flop sees pre-edge values
  // independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE_WAIT;
      div_q      <= '0;
      ms_q       <= '0;
      raw_q      <= '0;
      info_q     <= '0;
      valid_q    <= 1'b0;
      new_data_q <= 1'b0;
      err_q      <= 1'b0;
      retry_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ms_q       <= ms_d;
      raw_q      <= raw_d;
      info_q     <= info_d;
      valid_q    <= valid_d;
      new_data_q <= new_data_d;
      err_q      <= err_d;
      retry_q    <= retry_d;
    end
  end

  assign req         = (state_q == S_REQ);
  assign information = info_q;
  assign data_valid  = valid_q;
  assign new_data    = new_data_q;
  assign err         = err_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_dht_read_scheduler.sv
// Bench for dht_read_scheduler: absolute-time expectation model compared every
// cycle, plus directed scenarios with hand-computed latencies and frames.
module tb_dht_read_scheduler;

  localparam int CLK_FREQ   = 1000;
  localparam int PERIOD_MS  = 20;
  localparam int TIMEOUT_MS = 5;
  localparam int RETRY_MS   = 3;
  localparam int MAX_RETRY  = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        force_read;
  logic        req;
  logic        done;
  logic [39:0] raw_data;
  logic [31:0] information;
  logic        data_valid;
  logic        new_data;
  logic        err;
  logic [1:0]  retry_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dht_read_scheduler #(
    .CLK_FREQ  (CLK_FREQ),
    .PERIOD_MS (PERIOD_MS),
    .TIMEOUT_MS(TIMEOUT_MS),
    .RETRY_MS  (RETRY_MS),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .force_read (force_read),
    .req        (req),
    .done       (done),
    .raw_data   (raw_data),
    .information(information),
    .data_valid (data_valid),
    .new_data   (new_data),
    .err        (err),
    .retry_cnt  (retry_cnt)
  );

  // Model: timestamps of the next due request and of the open attempt,
  // expressed in absolute cycles (one tick per cycle at this clock rate).
  bit          m_on     = 1'b0;
  int          t        = 0;
  int          req_at   = -1;
  int          att_at   = -1;
  bit          forcible = 1'b0;
  bit          judging  = 1'b0;
  logic [39:0] frame    = '0;
  logic        exp_req  = 1'b0;
  logic        exp_new  = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_err  = 1'b0;
  logic [31:0] exp_info = '0;
  logic [1:0]  exp_retry = '0;

  function automatic bit frame_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return int'(f[7:0]) == (s % 256);
  endfunction

  task automatic fail_attempt();
    if (int'(exp_retry) == MAX_RETRY) begin
      exp_err   = 1'b1;
      exp_retry = 2'd0;
      forcible  = 1'b1;
      req_at    = t + PERIOD_MS;
    end else begin
      exp_retry = exp_retry + 2'd1;
      req_at    = t + RETRY_MS;
    end
  endtask

  initial forever begin
    @(posedge clk);
    t++;
    exp_new = 1'b0;
    if (!rstn) begin
      m_on      = 1'b1;
      exp_info  = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_retry = 2'd0;
      forcible  = 1'b1;
      judging   = 1'b0;
      att_at    = -1;
      req_at    = t + PERIOD_MS;
    end else if (m_on) begin
      if (judging) begin
        judging = 1'b0;
        if (frame_ok(frame)) begin
          exp_info  = frame[39:8];
          exp_valid = 1'b1;
          exp_new   = 1'b1;
          exp_err   = 1'b0;
          exp_retry = 2'd0;
          forcible  = 1'b1;
          req_at    = t + PERIOD_MS;
        end else begin
          fail_attempt();
        end
      end else if (att_at >= 0 && t - 1 > att_at) begin
        if (done) begin
          frame   = raw_data;
          judging = 1'b1;
          att_at  = -1;
        end else if (t - 1 == att_at + TIMEOUT_MS) begin
          att_at = -1;
          fail_attempt();
        end
      end else if (forcible && force_read) begin
        req_at = t;
      end
    end
    exp_req = m_on && (req_at == t);
    if (exp_req) begin
      att_at   = t;
      forcible = 1'b0;
      req_at   = -1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      n_vec++;
      if (req !== exp_req || new_data !== exp_new || information !== exp_info ||
          data_valid !== exp_valid || err !== exp_err || retry_cnt !== exp_retry) begin
        n_bad++;
        $display("FAIL model_cmp t=%0d (dut/model): req %b/%b new_data %b/%b info %h/%h valid %b/%b err %b/%b retry %0d/%0d",
                 t, req, exp_req, new_data, exp_new, information, exp_info,
                 data_valid, exp_valid, err, exp_err, retry_cnt, exp_retry);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns the number of falling edges until req is seen, bounded by limit.
  task automatic wait_req(input string name, input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req !== 1'b1 && waited < limit);
    if (req !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: req not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic forced_req(input string name);
    force_read = 1'b1;
    @(negedge clk);
    force_read = 1'b0;
    check(name, req, 1);
  endtask

  task automatic pulse_done(input logic [39:0] frame_in);
    @(negedge clk);
    done     = 1'b1;
    raw_data = frame_in;
    @(negedge clk);
    done     = 1'b0;
    raw_data = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rstn = 1'b0; force_read = 1'b0; done = 1'b0; raw_data = '0;
    repeat (3) @(negedge clk);
    check("rst_info", information, 0);
    check("rst_valid", data_valid, 0);
    check("rst_err_retry", {err, retry_cnt}, 0);
    rstn = 1'b1;

    // Scheduled read after release, good frame 37+00+19+00 = 0x50
    wait_req("first_req", 40, w);
    check("first_req_delay", w, PERIOD_MS);
    pulse_done(40'h37_00_19_00_50);
    check("new_data_not_early", new_data, 0);
    @(negedge clk);
    check("new_data_m2", new_data, 1);
    check("info_good", information, 32'h3700_1900);
    check("valid_good", data_valid, 1);

    // Forced read with bad checksum, then a good retry
    forced_req("force_latency");
    pulse_done(40'h37_00_19_00_45);
    @(negedge clk);
    check("retry_after_bad", retry_cnt, 1);
    check("info_kept_bad", information, 32'h3700_1900);
    wait_req("retry_req", 20, w);
    check("retry_gap", w, RETRY_MS);
    pulse_done(40'h0A_0B_0C_0D_2E);
    @(negedge clk);
    check("info_retry_good", information, 32'h0A0B_0C0D);
    check("retry_cleared", retry_cnt, 0);

    // Engine silent: four attempts spaced by timeout + gap + req cycle
    forced_req("silent_req1");
    for (int i = 0; i < 3; i++) begin
      wait_req("silent_req", 20, w);
      check("silent_spacing", w, 1 + TIMEOUT_MS + RETRY_MS);
    end
    repeat (TIMEOUT_MS) @(negedge clk);
    check("retry_before_exhaust", retry_cnt, 3);
    check("err_before_exhaust", err, 0);
    @(negedge clk);
    check("err_exhausted", err, 1);
    check("retry_exhausted", retry_cnt, 0);
    check("info_after_err", information, 32'h0A0B_0C0D);
    check("valid_after_err", data_valid, 1);

    // Checksum wraps: FF+01 = 0x100 -> 0x00
    forced_req("wrap_req");
    pulse_done(40'hFF_01_00_00_00);
    @(negedge clk);
    check("wrap_info", information, 32'hFF01_0000);
    check("wrap_err_clear", err, 0);

    // done coincides with timeout expiry: frame still judged
    forced_req("edge_req");
    repeat (TIMEOUT_MS - 1) @(negedge clk);
    pulse_done(40'h11_22_33_44_AA);
    @(negedge clk);
    check("edge_new_data", new_data, 1);
    check("edge_info", information, 32'h1122_3344);
    check("edge_retry", retry_cnt, 0);

    // done while idle is ignored
    pulse_done(40'h55_55_55_55_54);
    @(negedge clk);
    check("idle_done_new", new_data, 0);
    check("idle_done_info", information, 32'h1122_3344);

    // Reset mid-transaction, then a late done
    forced_req("abort_req");
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn     = 1'b1;
    done     = 1'b1;
    raw_data = 40'h37_00_19_00_50;
    @(negedge clk);
    done     = 1'b0;
    raw_data = '0;
    repeat (2) @(negedge clk);
    check("abort_info", information, 0);
    check("abort_flags", {data_valid, new_data, err, retry_cnt}, 0);
    wait_req("req_after_abort", 40, w);
    check("req_after_abort_delay", w + 3, PERIOD_MS);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
